fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset and on restart.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that stops the sequencer.
REQ-003 Parameter MAX_WAIT, default 16: maximum FETCH cycles without imem_ack before a fault.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level-sampled; begins or restarts execution.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  read address, equals pc.
REQ-009 imem_ack  input  1  read data valid this cycle.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 instruction  output  32  latched instruction word driven to the datapath.
REQ-012 currentInst  output  32  pc+4 driven to the datapath branch adder and PC mux.
REQ-013 next_pc  input  32  datapath programCounter result.
REQ-014 exec_valid  output  1  one-cycle strobe; datapath state update is permitted.
REQ-015 halted  output  1  high in HALT.
REQ-016 fault  output  1  sticky; high when HALT was entered through an error.
REQ-017 instr_count  output  32  count of executed instructions.

Function
REQ-018 The FSM SHALL use exactly four states: IDLE, FETCH, EXEC and HALT.
REQ-019 In IDLE, when start=1, the FSM SHALL go to FETCH; otherwise it SHALL remain in IDLE.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, with both held stable until imem_ack.
REQ-021 In FETCH, imem_ack SHALL be sampled every cycle; when it is 1, ir SHALL capture imem_rdata, wait_cnt SHALL clear, and the FSM SHALL go to EXEC, or to HALT if imem_rdata==HALT_WORD.
REQ-022 imem_ack SHALL be ignored whenever imem_req=0.
REQ-023 In FETCH without imem_ack, wait_cnt SHALL increment; when wait_cnt reaches MAX_WAIT-1 without ack, fault SHALL be set and the FSM SHALL go to HALT.
REQ-024 In EXEC, exec_valid SHALL be 1 for exactly one cycle and pc SHALL load next_pc.
REQ-025 In EXEC, instr_count SHALL increment modulo 2^32, and the FSM SHALL return to FETCH.
REQ-026 In EXEC, if next_pc[1:0]!=0, the FSM SHALL instead set fault, leave pc unchanged, not increment instr_count and go to HALT.
REQ-027 instruction SHALL equal ir at all times; currentInst SHALL equal pc+4 with 32-bit wrap (32'hFFFF_FFFC gives 0).
REQ-028 Minimum throughput SHALL be one instruction per 2 cycles, with imem_ack arriving in the first FETCH cycle.
REQ-029 In HALT, halted SHALL be 1, imem_req 0 and exec_valid 0.
REQ-030 In HALT, when start=1, pc SHALL load RESET_PC and fault, instr_count and wait_cnt SHALL clear, and the FSM SHALL go to IDLE.
REQ-031 A HALT_WORD fetch SHALL NOT produce exec_valid and SHALL NOT increment instr_count.
REQ-032 start SHALL be ignored in FETCH and EXEC.

Reset
REQ-033 On rst_n=0, asynchronously: state SHALL be IDLE, pc SHALL be RESET_PC, and ir, instr_count and wait_cnt SHALL be 0.
REQ-034 On rst_n=0, asynchronously: imem_req, exec_valid, halted and fault SHALL be 0.
REQ-035 Reset asserted mid-FETCH SHALL drop imem_req immediately, and a later imem_ack SHALL be ignored.
REQ-036 Release of rst_n SHALL take effect synchronously at the next clk edge.

Structure
REQ-037 The state enumeration, the HALT_WORD default and the 32-bit word width SHALL reside in the shared package mips_pkg.
REQ-038 No sub-module SHALL be used; the wait counter and FSM SHALL be implemented in one module, with the datapath instantiated alongside by the parent.

Verification
REQ-039 Scenario: reset, start=1, memory acks in the same cycle returning 32'h2008_0005, next_pc=4 -> imem_addr=0, exec_valid pulses in cycle 2, instr_count=1, imem_addr=4.
REQ-040 Scenario: ack delayed 5 cycles -> imem_req and imem_addr=0 held stable for 6 cycles, a single exec_valid, no fault.
REQ-041 Scenario: no ack with MAX_WAIT=16 -> HALT after 16 FETCH cycles, fault=1, halted=1, instr_count unchanged.
REQ-042 Scenario: fetch returns 32'hFFFF_FFFF -> HALT with fault=0 and no exec_valid; then start=1 -> IDLE, pc=RESET_PC, instr_count=0.
REQ-043 Scenario: next_pc=32'h0000_0006 in EXEC -> fault=1, pc unchanged, instr_count unchanged.
REQ-044 Scenario: rst_n pulsed low during FETCH wait -> imem_req=0 in the same cycle, state IDLE, and a stale ack causes no capture.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/sequencing front end: word width,
// halt encoding and the sequencer state enumeration.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Only the two low address bits decide word alignment.
  function automatic logic word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word at pc, lets the datapath execute
// it for one cycle, then loads the datapath's next_pc. Faults on timeout or misalignment.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter int                MAX_WAIT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] currentInst,
  input  logic [WORD_W-1:0] next_pc,
  output logic              exec_valid,
  output logic              halted,
  output logic              fault,
  output logic [WORD_W-1:0] instr_count
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  seq_state_t        state_reg;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] ir_reg;
  logic [WORD_W-1:0] count_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              imem_req_reg;
  logic              exec_valid_reg;
  logic              halted_reg;
  logic              fault_reg;

  // Output flags are registered alongside the state so each one is set on
  // the transition into the state it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      ir_reg         <= '0;
      count_reg      <= '0;
      wait_cnt_reg   <= '0;
      imem_req_reg   <= 1'b0;
      exec_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            ir_reg       <= imem_rdata;
            wait_cnt_reg <= '0;
            imem_req_reg <= 1'b0;
            if (imem_rdata == HALT_WORD) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg      <= EXEC;
              exec_valid_reg <= 1'b1;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            fault_reg    <= 1'b1;
            halted_reg   <= 1'b1;
            imem_req_reg <= 1'b0;
            state_reg    <= HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end

        EXEC: begin
          exec_valid_reg <= 1'b0;
          if (!word_aligned(next_pc[1:0])) begin
            // A misaligned target is never committed: pc and the count stay put.
            fault_reg  <= 1'b1;
            halted_reg <= 1'b1;
            state_reg  <= HALT;
          end else begin
            pc_reg       <= next_pc;
            count_reg    <= count_reg + 32'd1;
            imem_req_reg <= 1'b1;
            state_reg    <= FETCH;
          end
        end

        HALT: begin
          if (start) begin
            pc_reg       <= RESET_PC;
            fault_reg    <= 1'b0;
            count_reg    <= '0;
            wait_cnt_reg <= '0;
            halted_reg   <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        default: begin
          state_reg      <= IDLE;
          imem_req_reg   <= 1'b0;
          exec_valid_reg <= 1'b0;
          halted_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instruction = ir_reg;
  assign currentInst = pc_reg + 32'd4;
  assign exec_valid  = exec_valid_reg;
  assign halted      = halted_reg;
  assign fault       = fault_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: every acked non-halt fetch pushes an
// expected execution, popped when exec_valid is seen.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] next_pc = '0;
  logic        imem_req, exec_valid, halted, fault;
  logic [31:0] imem_addr, instruction, currentInst, instr_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_head;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hFFFF_FFFF),
    .MAX_WAIT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .currentInst(currentInst),
    .next_pc    (next_pc),
    .exec_valid (exec_valid),
    .halted     (halted),
    .fault      (fault),
    .instr_count(instr_count)
  );

  // Scoreboard consumer: each exec_valid cycle must match the oldest acked fetch.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && exec_valid === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_exec: got exec_valid at pc=%h, required no execution", imem_addr);
      end else begin
        sb_head = sb.pop_front();
        if (instruction !== sb_head.instr || imem_addr !== sb_head.pc ||
            currentInst !== sb_head.pc + 32'd4) begin
          mismatched++;
          $display("FAIL sb_exec: got instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                   instruction, imem_addr, currentInst, sb_head.instr, sb_head.pc,
                   sb_head.pc + 32'd4);
        end
        $display("exec pc=%h instr=%h count=%0d", imem_addr, instruction, instr_count);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then start: on return the sequencer is in FETCH at RESET_PC.
  task automatic do_reset;
    imem_ack = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n     = 1'b1;
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_fetch(input logic [31:0] w, input logic [31:0] npc);
    exp_t e;
    imem_ack   = 1'b1;
    imem_rdata = w;
    next_pc    = npc;
    if (w != 32'hFFFF_FFFF) begin
      e.instr = w;
      e.pc    = exp_pc;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({imem_req, exec_valid, halted, fault} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_flags: got req/ev/halt/fault=%b, required 0000",
               {imem_req, exec_valid, halted, fault});
    end
    compared++;
    if (imem_addr !== 32'h0 || instruction !== 32'h0 || instr_count !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_regs: got addr=%h ir=%h count=%h, required 0/0/0",
               imem_addr, instruction, instr_count);
    end
    compared++;
    if (currentInst !== 32'h4) begin
      mismatched++;
      $display("FAIL reset_pc4: got %h, required 00000004", currentInst);
    end
    tick();
    rst_n = 1'b1;
    tick();
    compared++;
    if (imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_no_start: got imem_req=%b, required 0", imem_req);
    end
  endtask

  task automatic test_basic;
    do_reset();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      mismatched++;
      $display("FAIL basic_fetch: got req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
    drive_fetch(32'h2008_0005, 32'h4);
    tick();
    imem_ack = 1'b0;
    compared++;
    if (exec_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_exec: got exec_valid=%b, required 1", exec_valid);
    end
    tick();
    exp_pc    = 32'h4;
    exp_count = 32'h1;
    compared++;
    if (exec_valid !== 1'b0 || instr_count !== exp_count || imem_addr !== exp_pc ||
        imem_req !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_after: got ev=%b count=%h addr=%h req=%b, required 0/%h/%h/1",
               exec_valid, instr_count, imem_addr, imem_req, exp_count, exp_pc);
    end
  endtask

  // Continues from test_basic: one instruction every two cycles, including the pc wrap.
  task automatic test_back_to_back;
    logic [31:0] targets[6];
    logic [31:0] w;
    targets = '{32'h8, 32'h100, 32'hFFFF_FFFC, 32'h0000_0010, 32'h20, 32'h24};
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      drive_fetch(w, targets[i]);
      tick();
      imem_ack = 1'b0;
      compared++;
      if (exec_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_exec[%0d]: got exec_valid=%b, required 1", i, exec_valid);
      end
      tick();
      exp_pc    = targets[i];
      exp_count = exp_count + 32'd1;
      compared++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_count !== exp_count ||
          currentInst !== exp_pc + 32'd4) begin
        mismatched++;
        $display("FAIL b2b_state[%0d]: got req=%b addr=%h count=%h pc4=%h, required 1/%h/%h/%h",
                 i, imem_req, imem_addr, instr_count, currentInst, exp_pc, exp_count,
                 exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_delayed_ack;
    int held;
    int pulses;
    held   = 0;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (imem_req === 1'b1 && imem_addr === 32'h0 && exec_valid === 1'b0) held++;
      tick();
    end
    if (imem_req === 1'b1 && imem_addr === 32'h0) held++;
    compared++;
    if (held != 6) begin
      mismatched++;
      $display("FAIL delay_hold: got %0d stable request cycles, required 6", held);
    end
    drive_fetch(32'h0123_4567, 32'h8);
    tick();
    imem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (exec_valid === 1'b1) pulses++;
      tick();
    end
    compared++;
    if (pulses != 1 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL delay_exec: got %0d pulses fault=%b, required 1 pulse fault=0", pulses, fault);
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    do_reset();
    drive_fetch(32'h1111_2222, 32'h8);
    tick();
    imem_ack = 1'b0;
    tick();
    for (int c = 0; c < 40 && halted !== 1'b1; c++) begin
      if (imem_req === 1'b1) n++;
      tick();
    end
    compared++;
    if (n != 16) begin
      mismatched++;
      $display("FAIL timeout_len: got %0d FETCH cycles, required 16", n);
    end
    compared++;
    if (fault !== 1'b1 || halted !== 1'b1 || instr_count !== 32'h1 || imem_req !== 1'b0 ||
        exec_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_halt: got fault=%b halted=%b count=%h req=%b ev=%b, required 1/1/1/0/0",
               fault, halted, instr_count, imem_req, exec_valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (fault !== 1'b0 || halted !== 1'b0 || instr_count !== 32'h0 || imem_addr !== 32'h0) begin
      mismatched++;
      $display("FAIL timeout_restart: got fault=%b halted=%b count=%h addr=%h, required 0/0/0/0",
               fault, halted, instr_count, imem_addr);
    end
  endtask

  task automatic test_halt_word;
    do_reset();
    drive_fetch(32'hAAAA_0001, 32'h4);
    tick();
    imem_ack = 1'b0;
    tick();
    drive_fetch(32'hFFFF_FFFF, 32'h40);
    tick();
    imem_ack = 1'b0;
    compared++;
    if (halted !== 1'b1 || fault !== 1'b0 || exec_valid !== 1'b0 ||
        instruction !== 32'hFFFF_FFFF || instr_count !== 32'h1) begin
      mismatched++;
      $display("FAIL halt_word: got halted=%b fault=%b ev=%b ir=%h count=%h, required 1/0/0/ffffffff/1",
               halted, fault, exec_valid, instruction, instr_count);
    end
    tick();
    tick();
    compared++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_hold: got halted=%b req=%b, required 1/0", halted, imem_req);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (halted !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_count !== 32'h0) begin
      mismatched++;
      $display("FAIL halt_restart: got halted=%b req=%b addr=%h count=%h, required 0/0/0/0",
               halted, imem_req, imem_addr, instr_count);
    end
  endtask

  task automatic test_misaligned;
    do_reset();
    drive_fetch(32'h0BAD_0001, 32'h10);
    tick();
    imem_ack = 1'b0;
    tick();
    exp_pc = 32'h10;
    drive_fetch(32'h0BAD_0002, 32'h6);
    tick();
    imem_ack = 1'b0;
    tick();
    compared++;
    if (fault !== 1'b1 || halted !== 1'b1 || imem_addr !== 32'h10 || instr_count !== 32'h1) begin
      mismatched++;
      $display("FAIL misaligned: got fault=%b halted=%b addr=%h count=%h, required 1/1/00000010/1",
               fault, halted, imem_addr, instr_count);
    end
  endtask

  task automatic test_reset_mid_fetch;
    do_reset();
    tick();
    tick();
    compared++;
    if (imem_req !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_pre: got imem_req=%b, required 1", imem_req);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_async: got imem_req=%b, required 0", imem_req);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    compared++;
    if (instruction !== 32'h0 || imem_req !== 1'b0 || exec_valid !== 1'b0 || halted !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_stale: got ir=%h req=%b ev=%b halted=%b, required 0/0/0/0",
               instruction, imem_req, exec_valid, halted);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_delayed_ack();
    test_timeout();
    test_halt_word();
    test_misaligned();
    test_reset_mid_fetch();
    tick();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d pending executions, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
